// File: rtl/link_frame_pkg.sv
// Shared types and helpers for the Aurora link framer/deframer pair:
// sync patterns, FSM states, header/trailer layouts and the CRC-32 step.
package link_frame_pkg;

  localparam logic [15:0] SYNC_HEAD_DEF  = 16'hA55A;
  localparam logic [15:0] SYNC_TRAIL_DEF = 16'h5AA5;
  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_PAYLOAD,
    ST_TRAIL,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [15:0] sync;
    logic [15:0] seq;
    logic [15:0] ftype;
    logic [15:0] rsvd;
  } head_t;

  typedef struct packed {
    logic [15:0] sync;
    logic        trunc;
    logic [14:0] count;
    logic [31:0] check;
  } trail_t;

  // One 64-bit word of CRC-32, MSB-first (data[63] enters first), no reflection.
  function automatic logic [31:0] crc32_d64(input logic [31:0] crc, input logic [63:0] data);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 63; i >= 0; i--) begin
      fb = c[31] ^ data[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/link_frame_chk.sv
// Payload check accumulator: XOR fold of the two 32-bit halves by default,
// CRC-32 (init/final-xor all ones) when LINK_TX_FRAMER_CRC_EN is defined.
module link_frame_chk
  import link_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [63:0] data_in,
  output logic [31:0] value_out
);

  logic [31:0] acc;

`ifdef LINK_TX_FRAMER_CRC_EN
  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (clear)  acc <= 32'hFFFF_FFFF;
    else if (enable) acc <= crc32_d64(acc, data_in);
  end

  assign value_out = ~acc;
`else
  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (clear)  acc <= '0;
    else if (enable) acc <= acc ^ data_in[63:32] ^ data_in[31:0];
  end

  assign value_out = acc;
`endif

endmodule

// File: rtl/link_tx_framer.sv
// Aurora TX framer: header + payload burst + trailer(count, check) on a
// single-register AXI-Stream output. Define LINK_TX_FRAMER_CRC_EN for CRC-32.
module link_tx_framer
  import link_frame_pkg::*;
#(
  parameter int          MAX_LEN    = 256,
  parameter logic [15:0] SYNC_HEAD  = SYNC_HEAD_DEF,
  parameter logic [15:0] SYNC_TRAIL = SYNC_TRAIL_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        channel_up,
  input  logic [63:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [15:0] s_ttype,
  output logic [63:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] frame_cnt,
  output logic [15:0] abort_cnt,
  output logic        busy
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_LEN);

  state_t      state;
  logic [15:0] seq;
  logic [15:0] ftype;
  logic [15:0] count;
  logic        trunc;
  logic        trail_loaded;
  logic        out_ready;
  logic        s_hs;
  logic        chk_clear;
  logic        chk_en;
  logic [31:0] chk_value;
  logic [15:0] count_nx;
  head_t       head_w;
  trail_t      trail_w;

  assign out_ready = ~m_tvalid | m_tready;
  assign s_tready  = (state == ST_PAYLOAD && channel_up && out_ready) || state == ST_DRAIN;
  assign s_hs      = s_tvalid & s_tready;
  assign busy      = (state != ST_IDLE);
  assign count_nx  = count + 16'd1;
  assign chk_clear = (state == ST_IDLE) && channel_up && s_tvalid;
  assign chk_en    = (state == ST_PAYLOAD) && s_hs;

  assign head_w  = '{sync: SYNC_HEAD, seq: seq, ftype: ftype, rsvd: 16'h0000};
  assign trail_w = '{sync: SYNC_TRAIL, trunc: trunc, count: count[14:0], check: chk_value};

  link_frame_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .clear     (chk_clear),
    .enable    (chk_en),
    .data_in   (s_tdata),
    .value_out (chk_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      seq          <= '0;
      ftype        <= '0;
      count        <= '0;
      trunc        <= 1'b0;
      trail_loaded <= 1'b0;
      frame_cnt    <= '0;
      abort_cnt    <= '0;
    end else if (!channel_up && (state == ST_HEAD || state == ST_PAYLOAD || state == ST_TRAIL)) begin
      // Channel loss: drop the in-flight word; only an unfinished burst needs draining.
      m_tvalid     <= 1'b0;
      trail_loaded <= 1'b0;
      if (abort_cnt != 16'hFFFF) abort_cnt <= abort_cnt + 16'd1;
      state <= (state == ST_TRAIL) ? ST_IDLE : ST_DRAIN;
    end else begin
      case (state)
        ST_IDLE: begin
          if (channel_up && s_tvalid) begin
            state <= ST_HEAD;
            ftype <= s_ttype;
            count <= '0;
            trunc <= 1'b0;
          end
        end
        ST_HEAD: begin
          if (!m_tvalid) begin
            m_tdata  <= head_w;
            m_tvalid <= 1'b1;
          end else if (m_tready) begin
            m_tvalid <= 1'b0;
            state    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (s_hs) begin
            m_tdata  <= s_tdata;
            m_tvalid <= 1'b1;
            count    <= count_nx;
            if (s_tlast) begin
              state <= ST_TRAIL;
            end else if (count_nx == MAX_CNT) begin
              trunc <= 1'b1;
              state <= ST_TRAIL;
            end
          end else if (m_tready) begin
            m_tvalid <= 1'b0;
          end
        end
        ST_TRAIL: begin
          // The last payload word may still occupy the register when we arrive.
          if (!trail_loaded) begin
            if (out_ready) begin
              m_tdata      <= trail_w;
              m_tvalid     <= 1'b1;
              trail_loaded <= 1'b1;
            end
          end else if (m_tready) begin
            m_tvalid     <= 1'b0;
            trail_loaded <= 1'b0;
            seq          <= seq + 16'd1;
            frame_cnt    <= frame_cnt + 32'd1;
            state        <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (s_hs && s_tlast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
